// File: rtl/ped_key_request_if.sv
// Handshake bundle between the pedestrian key front end and its user:
// raw key level and acknowledge in, latched request, press pulse and debounced level out.
interface ped_key_request_if;
  logic i_key_n;
  logic i_ack;
  logic o_req;
  logic o_press;
  logic o_key_state;

  modport master (
    output i_key_n,
    output i_ack,
    input  o_req,
    input  o_press,
    input  o_key_state
  );

  modport slave (
    input  i_key_n,
    input  i_ack,
    output o_req,
    output o_press,
    output o_key_state
  );
endinterface

// File: rtl/ped_key_request.sv
// Pedestrian push-button front end: synchronise and debounce the active-low key,
// pulse once per accepted press, and latch a crossing request with a post-ack hold-off.
module ped_key_request #(
  parameter logic [31:0] DEBOUNCE = 32'd1_000_000 - 32'd1,
  parameter logic [31:0] HOLDOFF  = 32'd50_000_000 - 32'd1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  ped_key_request_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PWAIT = 2'd1,
    DOWN  = 2'd2,
    RWAIT = 2'd3
  } state_e;

  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        key_s;
  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] holdoff_q, holdoff_d;
  logic        req_q, req_d;
  logic        press_q, press_d;
  logic        key_state_q, key_state_d;
  logic        ack_hit_s;

  // Next-state logic: synchroniser shift, debounce FSM, request latch and hold-off timer.
  always_comb begin
    sync1_d = bus.i_key_n;
    sync2_d = sync1_q;
    key_s   = ~sync2_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (key_s) begin
          state_d = PWAIT;
          cnt_d   = 32'd0;
        end else begin
          state_d = IDLE;
        end
      end
      PWAIT: begin
        if (!key_s) begin
          state_d = IDLE;
        end else if (cnt_q == DEBOUNCE) begin
          state_d = DOWN;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      DOWN: begin
        if (!key_s) begin
          state_d = RWAIT;
          cnt_d   = 32'd0;
        end else begin
          state_d = DOWN;
        end
      end
      RWAIT: begin
        if (key_s) begin
          state_d = DOWN;
        end else if (cnt_q == DEBOUNCE) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 32'd0;
      end
    endcase

    key_state_d = (state_d == DOWN) || (state_d == RWAIT);

    // An acknowledge only counts against a pending request, and it beats a same-edge press.
    ack_hit_s = bus.i_ack & req_q;
    if (ack_hit_s) begin
      req_d     = 1'b0;
      holdoff_d = HOLDOFF;
    end else begin
      if (press_d && (holdoff_q == 32'd0)) begin
        req_d = 1'b1;
      end else begin
        req_d = req_q;
      end
      if (holdoff_q != 32'd0) begin
        holdoff_d = holdoff_q - 32'd1;
      end else begin
        holdoff_d = 32'd0;
      end
    end
  end

  // State and output registers; reset releases the synchroniser to the unpressed level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= 32'd0;
      holdoff_q   <= 32'd0;
      req_q       <= 1'b0;
      press_q     <= 1'b0;
      key_state_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      holdoff_q   <= holdoff_d;
      req_q       <= req_d;
      press_q     <= press_d;
      key_state_q <= key_state_d;
    end
  end

  assign bus.o_req       = req_q;
  assign bus.o_press     = press_q;
  assign bus.o_key_state = key_state_q;

endmodule

// File: tb/tb_ped_key_request.sv
// Scenario bench for ped_key_request: expected press events are queued when a press is
// driven and checked (edge, request, level) when the DUT pulses o_press.
module tb_ped_key_request;
  localparam int DEB = 4;
  localparam int HO  = 9;
  localparam int LAT = DEB + 3;

  logic clk = 1'b0;
  logic rst_n;
  ped_key_request_if bus();

  ped_key_request #(
    .DEBOUNCE (32'd4),
    .HOLDOFF  (32'd9)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #10 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int press_cnt = 0;
  always @(negedge clk) if (bus.o_press === 1'b1) press_cnt <= press_cnt + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int   edge_at;
    logic req;
    logic ks;
  } exp_t;
  exp_t exp_q[$];

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_press(input string name);
    exp_t x;
    bit   found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.o_press === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL %s_timeout: o_press not seen within 60 cycles, required a pulse", name);
      if (exp_q.size() > 0) x = exp_q.pop_front();
    end else if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s_unexpected: o_press=1 at edge %0d, required no pulse", name, edge_n);
    end else begin
      x = exp_q.pop_front();
      checks += 4;
      if (edge_n !== x.edge_at) begin
        errors++;
        $display("FAIL %s_edge: pulse at edge %0d, required edge %0d", name, edge_n, x.edge_at);
      end
      if (bus.o_req !== x.req) begin
        errors++;
        $display("FAIL %s_req: o_req=%b, required %b", name, bus.o_req, x.req);
      end
      if (bus.o_key_state !== x.ks) begin
        errors++;
        $display("FAIL %s_ks: o_key_state=%b, required %b", name, bus.o_key_state, x.ks);
      end
      @(negedge clk);
      if (bus.o_press !== 1'b0) begin
        errors++;
        $display("FAIL %s_width: o_press=%b one cycle later, required 0", name, bus.o_press);
      end
    end
  endtask

  task automatic press_plain(input logic exp_req, input string name);
    exp_t x;
    bus.i_key_n = 1'b0;
    x.edge_at = edge_n + 1 + LAT;
    x.req     = exp_req;
    x.ks      = 1'b1;
    exp_q.push_back(x);
    wait_press(name);
  endtask

  task automatic release_key(input string name);
    int r;
    bus.i_key_n = 1'b1;
    r = edge_n + 1;
    while (edge_n < r + LAT - 1) @(negedge clk);
    checks++;
    if (bus.o_key_state !== 1'b1) begin
      errors++;
      $display("FAIL %s_early: o_key_state=%b at edge %0d, required 1", name, bus.o_key_state, edge_n);
    end
    @(negedge clk);
    checks++;
    if (bus.o_key_state !== 1'b0) begin
      errors++;
      $display("FAIL %s_fall: o_key_state=%b at edge %0d, required 0", name, bus.o_key_state, edge_n);
    end
  endtask

  // Press accepted 'off' edges after the acknowledge edge (0 = same edge).
  task automatic press_ack(input int off, input string name);
    exp_t x;
    int   e, a, last, nxt;
    e    = edge_n + 12;
    a    = e + LAT - off;
    last = (a > e) ? a : e;
    x.edge_at = e + LAT;
    x.req     = (off > HO) ? 1'b1 : 1'b0;
    x.ks      = 1'b1;
    exp_q.push_back(x);
    while (edge_n < last) begin
      nxt = edge_n + 1;
      if (nxt == e) bus.i_key_n = 1'b0;
      bus.i_ack = (nxt == a);
      @(negedge clk);
      if (edge_n == a && off > 0) begin
        checks++;
        if (bus.o_req !== 1'b0) begin
          errors++;
          $display("FAIL %s_ackclr: o_req=%b after ack, required 0", name, bus.o_req);
        end
      end
    end
    bus.i_ack = 1'b0;
    wait_press(name);
    hold(3);
    release_key({name, "_rel"});
  endtask

  task automatic ensure_req();
    if (bus.o_req !== 1'b1) begin
      press_plain(1'b1, "ensure");
      hold(3);
      release_key("ensure_rel");
    end
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    bus.i_key_n = 1'b1;
    bus.i_ack   = 1'b0;
    hold(2);
    rst_n = 1'b1;
    hold(2);
  endtask

  task automatic test_reset();
    exp_t x;
    rst_n       = 1'b0;
    bus.i_key_n = 1'b0;
    bus.i_ack   = 1'b0;
    hold(3);
    checks += 3;
    if (bus.o_req !== 1'b0) begin errors++; $display("FAIL rst_req: o_req=%b, required 0", bus.o_req); end
    if (bus.o_press !== 1'b0) begin errors++; $display("FAIL rst_press: o_press=%b, required 0", bus.o_press); end
    if (bus.o_key_state !== 1'b0) begin errors++; $display("FAIL rst_ks: o_key_state=%b, required 0", bus.o_key_state); end
    rst_n = 1'b1;
    x.edge_at = edge_n + 1 + LAT;
    x.req     = 1'b1;
    x.ks      = 1'b1;
    exp_q.push_back(x);
    wait_press("reset_press");
    hold(2);
    release_key("reset_rel");
  endtask

  task automatic test_bounce();
    int pc0;
    do_reset();
    pc0 = press_cnt;
    bus.i_key_n = 1'b0; hold(3);
    bus.i_key_n = 1'b1; hold(1);
    bus.i_key_n = 1'b0; hold(3);
    bus.i_key_n = 1'b1; hold(15);
    checks += 3;
    if (press_cnt !== pc0) begin errors++; $display("FAIL bounce_press: %0d pulses, required 0", press_cnt - pc0); end
    if (bus.o_req !== 1'b0) begin errors++; $display("FAIL bounce_req: o_req=%b, required 0", bus.o_req); end
    if (bus.o_key_state !== 1'b0) begin errors++; $display("FAIL bounce_ks: o_key_state=%b, required 0", bus.o_key_state); end
  endtask

  task automatic test_clean_press();
    int pc0;
    pc0 = press_cnt;
    press_plain(1'b1, "clean");
    hold(18);
    release_key("clean_rel");
    hold(10);
    checks++;
    if (press_cnt !== pc0 + 1) begin
      errors++;
      $display("FAIL clean_count: %0d pulses, required 1", press_cnt - pc0);
    end
  endtask

  task automatic test_holdoff();
    int offs[4] = '{5, 12, 9, 10};
    for (int i = 0; i < 4; i++) begin
      ensure_req();
      press_ack(offs[i], $sformatf("holdoff_%0d", offs[i]));
    end
  endtask

  task automatic test_ack_collision();
    ensure_req();
    press_ack(0, "collide");
  endtask

  task automatic test_reset_midop();
    int pc0;
    press_plain(1'b1, "midop_press");
    hold(3);
    bus.i_key_n = 1'b1;
    hold(4);
    checks += 2;
    if (bus.o_req !== 1'b1) begin errors++; $display("FAIL midop_pre_req: o_req=%b, required 1", bus.o_req); end
    if (bus.o_key_state !== 1'b1) begin errors++; $display("FAIL midop_pre_ks: o_key_state=%b, required 1", bus.o_key_state); end
    rst_n = 1'b0;
    #2;
    checks += 3;
    if (bus.o_req !== 1'b0) begin errors++; $display("FAIL midop_req: o_req=%b, required 0", bus.o_req); end
    if (bus.o_press !== 1'b0) begin errors++; $display("FAIL midop_press: o_press=%b, required 0", bus.o_press); end
    if (bus.o_key_state !== 1'b0) begin errors++; $display("FAIL midop_ks: o_key_state=%b, required 0", bus.o_key_state); end
    @(negedge clk);
    rst_n = 1'b1;
    pc0 = press_cnt;
    hold(21);
    checks += 2;
    if (press_cnt !== pc0) begin errors++; $display("FAIL midop_nopress: %0d pulses, required 0", press_cnt - pc0); end
    if (bus.o_req !== 1'b0) begin errors++; $display("FAIL midop_post_req: o_req=%b, required 0", bus.o_req); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_bounce();
    test_clean_press();
    test_holdoff();
    test_ack_collision();
    test_reset_midop();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
